ika9958_vram_slot_arb: RTL

IKA9958_VRAM_SLOT_ARB -- requirements
Module: ika9958_vram_slot_arb

---
 rtl/ika9958_vram_slot_arb.sv | 112 +++++++++++
 1 files changed

// File: rtl/ika9958_vram_slot_arb.sv
// VRAM access-slot arbiter: divides each line into fixed-length slots and grants each slot to
// refresh, display fetch, the command engine or the CPU. Refresh rule: IKA9958_VRAM_ARB_RFSH_EN.
module ika9958_vram_slot_arb #(
  parameter int unsigned SLOT_LEN     = 4,
  parameter int unsigned SLOT_MAX     = 84,
  parameter int unsigned REFRESH_SLOT = 84,
  parameter int unsigned STARVE_MAX   = 3
) (
  input  logic       i_phiA,
  input  logic       i_RST,
  input  logic       i_phiL_NCEN,
  input  logic       i_HSTART,
  input  logic       i_DISP_ACTIVE,
  input  logic       i_DISP_EN,
  input  logic       i_CPU_REQ,
  input  logic       i_CMD_REQ,
  output logic       o_CPU_GNT,
  output logic       o_CMD_GNT,
  output logic       o_DISP_GNT,
  output logic       o_RFSH_GNT,
  output logic       o_SLOT_START,
  output logic [6:0] o_SLOT_IDX
);

`ifdef IKA9958_VRAM_ARB_RFSH_EN
  localparam bit RfshEn = 1'b1;
`else
  localparam bit RfshEn = 1'b0;
`endif

  localparam int unsigned PW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  localparam logic [PW-1:0] PhaseLast = PW'(SLOT_LEN - 1);
  localparam logic [6:0]    IdxLast   = 7'(SLOT_MAX);
  localparam logic [6:0]    IdxRfsh   = 7'(REFRESH_SLOT);
  localparam logic [SW-1:0] StarveTop = SW'(STARVE_MAX);

  // Grant vector bit positions.
  localparam int unsigned GCpu  = 0;
  localparam int unsigned GCmd  = 1;
  localparam int unsigned GDisp = 2;
  localparam int unsigned GRfsh = 3;

  logic [PW-1:0] phase_q, phase_d;
  logic [6:0]    idx_q, idx_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [3:0]    gnt_q, gnt_d;
  logic          run_q;
  logic          boundary;

  always_comb begin
    phase_d  = phase_q;
    idx_d    = idx_q;
    starve_d = starve_q;
    gnt_d    = gnt_q;
    boundary = i_phiL_NCEN && (i_HSTART || phase_q == PhaseLast);

    if (boundary) begin
      phase_d = '0;
      idx_d   = (i_HSTART || idx_q == IdxLast) ? 7'd0 : idx_q + 7'd1;
      gnt_d   = '0;
      if (RfshEn && idx_d == IdxRfsh) begin
        gnt_d[GRfsh] = 1'b1;
      end else if (i_DISP_ACTIVE && i_DISP_EN && idx_d[1:0] != 2'b00) begin
        gnt_d[GDisp] = 1'b1;
      end else if (i_CMD_REQ && starve_q == StarveTop) begin
        gnt_d[GCmd] = 1'b1;
      end else if (i_CPU_REQ) begin
        gnt_d[GCpu] = 1'b1;
      end else if (i_CMD_REQ) begin
        gnt_d[GCmd] = 1'b1;
      end

      // Starvation only accrues while the command engine is actually waiting.
      if (!i_CMD_REQ || gnt_d[GCmd]) begin
        starve_d = '0;
      end else if (gnt_d[GCpu] && starve_q != StarveTop) begin
        starve_d = starve_q + SW'(1);
      end
    end else if (i_phiL_NCEN) begin
      phase_d = phase_q + PW'(1);
    end
  end

  always_ff @(posedge i_phiA) begin
    if (i_RST) begin
      phase_q  <= '0;
      idx_q    <= '0;
      starve_q <= '0;
      gnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      starve_q <= starve_d;
      gnt_q    <= gnt_d;
      if (i_phiL_NCEN) begin
        run_q <= 1'b1;
      end
    end
  end

  assign o_CPU_GNT    = gnt_q[GCpu];
  assign o_CMD_GNT    = gnt_q[GCmd];
  assign o_DISP_GNT   = gnt_q[GDisp];
  assign o_RFSH_GNT   = RfshEn & gnt_q[GRfsh];
  // Slot-start stays low after reset until the first enabled tick has been taken.
  assign o_SLOT_START = run_q && (phase_q == '0);
  assign o_SLOT_IDX   = idx_q;

endmodule
